// File: rtl/computer_system_key_edge_pio.sv
// Avalon-MM input PIO: synchronises and debounces external pins, latches the selected
// edge type into a write-1-to-clear capture register and raises a level interrupt.
module computer_system_key_edge_pio #(
    parameter int unsigned WIDTH      = 4,
    parameter int unsigned DEBOUNCE   = 16,
    parameter int unsigned EDGE_TYPE  = 1,
    parameter bit          IDLE_LEVEL = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);
    localparam int unsigned      CntW    = $clog2(DEBOUNCE + 1);
    localparam logic [CntW-1:0]  CntLast = CntW'(DEBOUNCE - 1);
    localparam logic [WIDTH-1:0] IdleVec = {WIDTH{IDLE_LEVEL}};

    logic [WIDTH-1:0]           sync1_q, sync2_q;
    logic [WIDTH-1:0]           stable_q, stable_d;
    logic [WIDTH-1:0][CntW-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0]           accept, rising, falling, edge_hit;
    logic [WIDTH-1:0]           mask_q, mask_d;
    logic [WIDTH-1:0]           cap_q, cap_d, clr;
    logic                       wr_en;
    logic                       unused_wdata;

    // A change is accepted only after DEBOUNCE consecutive disagreeing samples.
    always_comb begin
        cnt_d    = cnt_q;
        stable_d = stable_q;
        accept   = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (sync2_q[i] == stable_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CntLast) begin
                accept[i]   = 1'b1;
                stable_d[i] = sync2_q[i];
                cnt_d[i]    = '0;
            end else begin
                cnt_d[i] = cnt_q[i] + 1'b1;
            end
        end
    end

    always_comb begin
        rising  = accept & sync2_q;
        falling = accept & ~sync2_q;
        if (EDGE_TYPE == 0) begin
            edge_hit = rising;
        end else if (EDGE_TYPE == 1) begin
            edge_hit = falling;
        end else begin
            edge_hit = accept;
        end
    end

    assign wr_en        = chipselect & ~write_n;
    assign unused_wdata = ^writedata;

    // A new edge on the same bit as a clear wins, so set is OR-ed in last.
    always_comb begin
        clr    = (wr_en && address == 2'd3) ? writedata[WIDTH-1:0] : '0;
        cap_d  = (cap_q & ~clr) | edge_hit;
        mask_d = (wr_en && address == 2'd2) ? writedata[WIDTH-1:0] : mask_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync1_q  <= IdleVec;
            sync2_q  <= IdleVec;
            stable_q <= IdleVec;
            cnt_q    <= '0;
            mask_q   <= '0;
            cap_q    <= '0;
        end else begin
            sync1_q  <= in_port;
            sync2_q  <= sync1_q;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            mask_q   <= mask_d;
            cap_q    <= cap_d;
        end
    end

    always_comb begin
        readdata = '0;
        unique case (address)
            2'd0:    readdata = 32'(stable_q);
            2'd1:    readdata = '0;
            2'd2:    readdata = 32'(mask_q);
            2'd3:    readdata = 32'(cap_q);
            default: readdata = '0;
        endcase
    end

    assign irq = |(cap_q & mask_q);

endmodule

// File: tb/tb_computer_system_key_edge_pio.sv
// Bench for the key edge PIO: directed scenarios plus randomized traffic, with two
// instances (falling/16-cycle and any-edge/4-cycle) checked against a window-based model.
module tb_computer_system_key_edge_pio;
    logic        clk        = 1'b0;
    logic        reset      = 1'b1;
    logic [1:0]  address    = 2'd0;
    logic        chipselect = 1'b0;
    logic        write_n    = 1'b1;
    logic [31:0] writedata  = 32'd0;
    logic [3:0]  in_port    = 4'hF;
    logic [31:0] readdata_a, readdata_b;
    logic        irq_a, irq_b;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    computer_system_key_edge_pio #(
        .WIDTH(4), .DEBOUNCE(16), .EDGE_TYPE(1), .IDLE_LEVEL(1'b1)
    ) dut_a (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata_a), .irq(irq_a)
    );

    computer_system_key_edge_pio #(
        .WIDTH(4), .DEBOUNCE(4), .EDGE_TYPE(2), .IDLE_LEVEL(1'b1)
    ) dut_b (
        .clk(clk), .reset(reset), .address(address), .chipselect(chipselect),
        .write_n(write_n), .writedata(writedata), .in_port(in_port),
        .readdata(readdata_b), .irq(irq_b)
    );

    // Reference: a bit flips when the last D synchronised samples all disagree with it.
    int unsigned dbn [2] = '{16, 4};
    int unsigned ety [2] = '{1, 2};
    logic [3:0]  m_s1 [2];
    logic [3:0]  m_s2 [2];
    logic [3:0]  m_stable [2];
    logic [3:0]  m_mask [2];
    logic [3:0]  m_cap [2];
    logic [3:0]  m_hist [2][16];

    task automatic model_step();
        logic [3:0] seen, flip, newv, setb, clr;
        logic       wr;
        wr = chipselect && !write_n;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                m_s1[d] = 4'hF; m_s2[d] = 4'hF; m_stable[d] = 4'hF;
                m_mask[d] = 4'h0; m_cap[d] = 4'h0;
                for (int k = 0; k < 16; k++) m_hist[d][k] = 4'hF;
            end else begin
                seen = m_s2[d];
                m_s2[d] = m_s1[d];
                m_s1[d] = in_port;
                for (int k = 15; k > 0; k--) m_hist[d][k] = m_hist[d][k-1];
                m_hist[d][0] = seen;
                flip = 4'h0;
                for (int b = 0; b < 4; b++) begin
                    flip[b] = 1'b1;
                    for (int k = 0; k < int'(dbn[d]); k++)
                        if (m_hist[d][k][b] == m_stable[d][b]) flip[b] = 1'b0;
                end
                newv = m_stable[d] ^ flip;
                if (ety[d] == 0)      setb = flip & newv;
                else if (ety[d] == 1) setb = flip & ~newv;
                else                  setb = flip;
                m_stable[d] = newv;
                clr = (wr && address == 2'd3) ? writedata[3:0] : 4'h0;
                m_cap[d] = (m_cap[d] & ~clr) | setb;
                if (wr && address == 2'd2) m_mask[d] = writedata[3:0];
            end
        end
    endtask

    function automatic logic [31:0] exp_rd(int d);
        case (address)
            2'd0:    return {28'd0, m_stable[d]};
            2'd2:    return {28'd0, m_mask[d]};
            2'd3:    return {28'd0, m_cap[d]};
            default: return 32'd0;
        endcase
    endfunction

    task automatic chk32(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(string tag, logic obs, logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        chk32("model_rd_a", readdata_a, exp_rd(0));
        chk32("model_rd_b", readdata_b, exp_rd(1));
        chk1("model_irq_a", irq_a, |(m_cap[0] & m_mask[0]));
        chk1("model_irq_b", irq_b, |(m_cap[1] & m_mask[1]));
    endtask

    task automatic ticks(int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic wr(logic [1:0] a, logic [31:0] v);
        address = a; writedata = v; chipselect = 1'b1; write_n = 1'b0;
        tick();
        chipselect = 1'b0; write_n = 1'b1;
    endtask

    task automatic expect_rd(int d, logic [1:0] a, logic [31:0] v, string tag);
        address = a;
        #1;
        chk32(tag, (d == 0) ? readdata_a : readdata_b, v);
    endtask

    initial begin
        // Reset and idle
        reset = 1'b1; in_port = 4'hF;
        ticks(2);
        reset = 1'b0;
        ticks(100);
        expect_rd(0, 2'd0, 32'hF, "idle_data");
        expect_rd(0, 2'd1, 32'h0, "addr1_zero");
        expect_rd(0, 2'd2, 32'h0, "idle_mask");
        expect_rd(0, 2'd3, 32'h0, "idle_cap");
        chk1("idle_irq", irq_a, 1'b0);

        // Falling edge on bit0, latency N+17
        wr(2'd2, 32'h1);
        in_port = 4'hE;
        ticks(17);
        expect_rd(0, 2'd0, 32'hF, "lat_data_early");
        expect_rd(0, 2'd3, 32'h0, "lat_cap_early");
        chk1("lat_irq_early", irq_a, 1'b0);
        tick();
        expect_rd(0, 2'd0, 32'hE, "lat_data");
        expect_rd(0, 2'd3, 32'h1, "lat_cap");
        chk1("lat_irq", irq_a, 1'b1);

        in_port = 4'hF;
        ticks(20);
        wr(2'd3, 32'h1);
        expect_rd(0, 2'd3, 32'h0, "clr_bit0");

        // Bounce on bit1
        in_port = 4'hD; ticks(10);
        in_port = 4'hF; ticks(2);
        in_port = 4'hD;
        ticks(17);
        expect_rd(0, 2'd3, 32'h0, "bounce_cap_early");
        expect_rd(0, 2'd0, 32'hF, "bounce_data_early");
        tick();
        expect_rd(0, 2'd3, 32'h2, "bounce_cap");
        expect_rd(0, 2'd0, 32'hD, "bounce_data");
        ticks(3);

        // W1C and irq
        wr(2'd2, 32'h3);
        chk1("mask_irq", irq_a, 1'b1);
        wr(2'd3, 32'h0);
        expect_rd(0, 2'd3, 32'h2, "w0_nochange");
        wr(2'd3, 32'h2);
        expect_rd(0, 2'd3, 32'h0, "w1c_cap");
        chk1("w1c_irq", irq_a, 1'b0);

        // Clear in the same cycle as acceptance: set wins
        in_port = 4'h9;
        ticks(17);
        wr(2'd3, 32'h4);
        expect_rd(0, 2'd3, 32'h4, "set_wins_cap");
        expect_rd(0, 2'd0, 32'h9, "set_wins_data");
        chk1("set_wins_irq", irq_a, 1'b0);
        ticks(5);

        // Any-edge instance: press and release bit3
        wr(2'd3, 32'hF);
        in_port = 4'h1;
        ticks(5);
        expect_rd(1, 2'd0, 32'h9, "any_press_early");
        tick();
        expect_rd(1, 2'd0, 32'h1, "any_press_data");
        expect_rd(1, 2'd3, 32'h8, "any_press_cap");
        in_port = 4'h9;
        ticks(5);
        expect_rd(1, 2'd0, 32'h1, "any_rel_early");
        tick();
        expect_rd(1, 2'd0, 32'h9, "any_rel_data");
        expect_rd(1, 2'd3, 32'h8, "any_rel_cap");

        // Reset mid-count discards pending change; count restarts afterwards
        in_port = 4'hF;
        ticks(20);
        in_port = 4'h7;
        ticks(10);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        expect_rd(0, 2'd3, 32'h0, "rst_cap_cleared");
        ticks(17);
        expect_rd(0, 2'd3, 32'h0, "rst_no_capture");
        expect_rd(0, 2'd0, 32'hF, "rst_data_idle");
        tick();
        expect_rd(0, 2'd3, 32'h8, "rst_recount_cap");
        expect_rd(0, 2'd0, 32'h7, "rst_recount_data");

        // Randomized traffic against the model
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 11) == 0) in_port = in_port ^ 4'($urandom_range(1, 15));
            address    = 2'($urandom_range(0, 3));
            chipselect = 1'($urandom_range(0, 1));
            write_n    = ($urandom_range(0, 5) != 0);
            writedata  = $urandom();
            reset      = ($urandom_range(0, 999) == 0);
            tick();
        end
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
